pipelined_register_file: RTL and testbench

Parametrised, clocked successor of the ID-stage register file for the pipelined MIPS datapath. It has two combinational read ports with write-through bypass, so a WB write and an ID read in the same cycle need no extra forwarding path. Writes are synchronous. An optional hardwired-zero register 0 and a deterministic reset preload are provided. An integrated busy scoreboard tracks registers with an in-flight producer, so hazard detection can stall on load-use.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 45 ++++
 rtl/pipelined_register_file.sv | 76 +++++++
 tb/tb_pipelined_register_file.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the reset preload rule for the pipelined register file.
package regfile_pkg;

  localparam int RF_DATA_W     = 32;
  localparam int RF_DEPTH      = 32;
  localparam int RF_RESET_STEP = 10;

  // Full-width product; the caller truncates it to its own register width.
  function automatic logic [63:0] preload_value(input int unsigned index,
                                                input int unsigned step);
    return 64'(index) * 64'(step);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per register: set when a producer issues, cleared when it writes back.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = RF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy
);

  localparam logic HAS_ZERO = (ZERO_REG != 0);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && !(HAS_ZERO && (set_addr == '0))) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
    // Set is applied after clear so a newer producer on the same register wins.
    busy_next = (busy & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign rs_busy = busy[rs_addr];
  assign rt_busy = busy[rt_addr];

endmodule

// File: rtl/pipelined_register_file.sv
// Two-read/one-write register file with write-through bypass, optional
// hardwired zero register, deterministic reset preload and busy scoreboard.
module pipelined_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int DEPTH      = RF_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int ZERO_REG   = 1,
  parameter int RESET_STEP = RF_RESET_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RsAddr,
  input  logic [ADDR_W-1:0] RtAddr,
  output logic [DATA_W-1:0] RsData,
  output logic [DATA_W-1:0] RtData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueAddress,
  output logic              RsBusy,
  output logic              RtBusy
);

  localparam logic HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              write_zero;
  logic              write_live;
  logic              rs_zero;
  logic              rt_zero;

  assign write_zero = HAS_ZERO && (WriteAddress == '0);
  assign write_live = rst_n && RegWrite && !write_zero;
  assign rs_zero    = HAS_ZERO && (RsAddr == '0);
  assign rt_zero    = HAS_ZERO && (RtAddr == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= DATA_W'(preload_value(i, RESET_STEP));
    end else if (write_live) begin
      regs[WriteAddress] <= WriteData;
    end
  end

  // A write landing this cycle is forwarded so ID sees the WB result directly.
  always_comb begin
    RsData = regs[RsAddr];
    RtData = regs[RtAddr];
    if (write_live && (WriteAddress == RsAddr)) RsData = WriteData;
    if (write_live && (WriteAddress == RtAddr)) RtData = WriteData;
    if (rs_zero) RsData = '0;
    if (rt_zero) RtData = '0;
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (IssueValid),
    .set_addr (IssueAddress),
    .clr_en   (RegWrite),
    .clr_addr (WriteAddress),
    .rs_addr  (RsAddr),
    .rt_addr  (RtAddr),
    .rs_busy  (RsBusy),
    .rt_busy  (RtBusy)
  );

endmodule

// File: tb/tb_pipelined_register_file.sv
// Bench for pipelined_register_file: default build (table, random model run)
// and a 16-bit/8-entry build without a zero register.
module tb_pipelined_register_file;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ers;
    logic [31:0] ert;
    logic        erb;
    logic        etb;
  } vec_t;

  // clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default build signals
  logic        rst_n = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0, wr_addr = '0, iss_addr = '0;
  logic [31:0] rs_data, rt_data, wr_data = '0;
  logic        reg_write = 1'b0, iss_valid = 1'b0, rs_busy, rt_busy;

  // small build signals
  logic        p_rst_n = 1'b0;
  logic [2:0]  p_rs_addr = '0, p_rt_addr = '0, p_wr_addr = '0, p_iss_addr = '0;
  logic [15:0] p_rs_data, p_rt_data, p_wr_data = '0;
  logic        p_reg_write = 1'b0, p_iss_valid = 1'b0, p_rs_busy, p_rt_busy;

  pipelined_register_file dut (
    .clk(clk), .rst_n(rst_n), .RsAddr(rs_addr), .RtAddr(rt_addr),
    .RsData(rs_data), .RtData(rt_data), .RegWrite(reg_write),
    .WriteAddress(wr_addr), .WriteData(wr_data), .IssueValid(iss_valid),
    .IssueAddress(iss_addr), .RsBusy(rs_busy), .RtBusy(rt_busy)
  );

  pipelined_register_file #(
    .DATA_W(16), .DEPTH(8), .ZERO_REG(0), .RESET_STEP(4000)
  ) dut_p (
    .clk(clk), .rst_n(p_rst_n), .RsAddr(p_rs_addr), .RtAddr(p_rt_addr),
    .RsData(p_rs_data), .RtData(p_rt_data), .RegWrite(p_reg_write),
    .WriteAddress(p_wr_addr), .WriteData(p_wr_data), .IssueValid(p_iss_valid),
    .IssueAddress(p_iss_addr), .RsBusy(p_rs_busy), .RtBusy(p_rt_busy)
  );

  // scoreboard
  logic [65:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare(input string tag, input logic [31:0] a_rs, input logic [31:0] a_rt,
                         input logic a_rsb, input logic a_rtb);
    logic [65:0] e;
    e = exp_q.pop_front();
    check({tag, " RsData"}, a_rs, e[65:34]);
    check({tag, " RtData"}, a_rt, e[33:2]);
    check({tag, " RsBusy"}, 32'(a_rsb), 32'(e[1]));
    check({tag, " RtBusy"}, 32'(a_rtb), 32'(e[0]));
  endtask

  // driver tasks
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst_n = v.rst; reg_write = v.we; wr_addr = v.wa; wr_data = v.wd;
    iss_valid = v.iv; iss_addr = v.ia; rs_addr = v.rs; rt_addr = v.rt;
    exp_q.push_back({v.ers, v.ert, v.erb, v.etb});
    #2;
    compare(tag, rs_data, rt_data, rs_busy, rt_busy);
  endtask

  task automatic apply_p(input logic r, input logic we, input logic [2:0] wa,
                         input logic [15:0] wd, input logic iv, input logic [2:0] ia,
                         input logic [2:0] rs, input logic [2:0] rt,
                         input logic [15:0] ers, input logic [15:0] ert,
                         input logic erb, input logic etb, input string tag);
    @(negedge clk);
    p_rst_n = r; p_reg_write = we; p_wr_addr = wa; p_wr_data = wd;
    p_iss_valid = iv; p_iss_addr = ia; p_rs_addr = rs; p_rt_addr = rt;
    exp_q.push_back({16'h0, ers, 16'h0, ert, erb, etb});
    #2;
    compare(tag, 32'(p_rs_data), 32'(p_rt_data), p_rs_busy, p_rt_busy);
  endtask

  function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic iv, input logic [4:0] ia,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [31:0] ers, input logic [31:0] ert,
                              input logic erb, input logic etb);
    vec_t v;
    v.rst = r; v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia;
    v.rs = rs; v.rt = rt; v.ers = ers; v.ert = ert; v.erb = erb; v.etb = etb;
    return v;
  endfunction

  // reference state for the random run
  logic [31:0] mem [32];
  logic [31:0] bsy;

  vec_t vt [20];
  vec_t rv;

  initial begin
    vt[0]  = mk(1, 0, 0, 0,            0, 0, 5,  31, 50,           310,          0, 0);
    vt[1]  = mk(1, 0, 0, 0,            0, 0, 0,  1,  0,            10,           0, 0);
    vt[2]  = mk(1, 1, 7, 32'hDEADBEEF, 0, 0, 7,  7,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vt[3]  = mk(1, 0, 0, 0,            0, 0, 7,  7,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vt[4]  = mk(1, 1, 0, 123,          1, 0, 0,  0,  0,            0,            0, 0);
    vt[5]  = mk(1, 0, 0, 0,            0, 0, 0,  0,  0,            0,            0, 0);
    vt[6]  = mk(1, 0, 0, 0,            1, 9, 1,  9,  10,           90,           0, 0);
    vt[7]  = mk(1, 0, 0, 0,            0, 0, 1,  9,  10,           90,           0, 1);
    vt[8]  = mk(1, 1, 9, 555,          0, 0, 9,  9,  555,          555,          1, 1);
    vt[9]  = mk(1, 0, 0, 0,            0, 0, 9,  9,  555,          555,          0, 0);
    vt[10] = mk(1, 1, 9, 600,          1, 9, 9,  9,  600,          600,          0, 0);
    vt[11] = mk(1, 0, 0, 0,            0, 0, 9,  9,  600,          600,          1, 1);
    vt[12] = mk(1, 1, 9, 700,          1, 4, 4,  9,  40,           700,          0, 1);
    vt[13] = mk(1, 0, 0, 0,            0, 0, 4,  9,  40,           700,          1, 0);
    vt[14] = mk(1, 1, 3, 77,           1, 3, 3,  3,  77,           77,           0, 0);
    vt[15] = mk(0, 1, 3, 99,           0, 0, 3,  3,  77,           77,           1, 1);
    vt[16] = mk(1, 0, 0, 0,            0, 0, 3,  4,  30,           40,           0, 0);
    vt[17] = mk(1, 0, 0, 0,            0, 0, 7,  31, 70,           310,          0, 0);
    vt[18] = mk(1, 1, 31, 32'h12345678, 0, 0, 31, 30, 32'h12345678, 300,         0, 0);
    vt[19] = mk(1, 0, 0, 0,            0, 0, 31, 31, 32'h12345678, 32'h12345678, 0, 0);

    // initial reset of both builds, outputs are undefined until that edge
    @(negedge clk);
    rst_n = 1'b0;
    p_rst_n = 1'b0;

    for (int i = 0; i < 20; i++) apply(vt[i], $sformatf("vec%0d", i));

    // random run against a reference model seeded with the table's final state
    for (int i = 0; i < 32; i++) mem[i] = 32'(i * 10);
    mem[31] = 32'h12345678;
    bsy = '0;
    for (int n = 0; n < 150; n++) begin
      rv.rst = ($urandom_range(0, 15) != 0);
      rv.we  = 1'($urandom_range(0, 1));
      rv.iv  = 1'($urandom_range(0, 1));
      rv.wd  = $urandom;
      rv.rs  = 5'($urandom_range(0, 31));
      rv.rt  = ($urandom_range(0, 3) == 0) ? rv.rs : 5'($urandom_range(0, 31));
      rv.wa  = ($urandom_range(0, 2) == 0) ? rv.rs : 5'($urandom_range(0, 31));
      rv.ia  = ($urandom_range(0, 2) == 0) ? rv.wa : 5'($urandom_range(0, 31));
      rv.ers = (rv.rs == 0) ? 32'h0 : (rv.rst && rv.we && rv.wa == rv.rs) ? rv.wd : mem[rv.rs];
      rv.ert = (rv.rt == 0) ? 32'h0 : (rv.rst && rv.we && rv.wa == rv.rt) ? rv.wd : mem[rv.rt];
      rv.erb = bsy[rv.rs];
      rv.etb = bsy[rv.rt];
      apply(rv, $sformatf("rnd%0d", n));
      if (!rv.rst) begin
        for (int i = 0; i < 32; i++) mem[i] = 32'(i * 10);
        bsy = '0;
      end else begin
        if (rv.we && rv.wa != 0) mem[rv.wa] = rv.wd;
        if (rv.we) bsy[rv.wa] = 1'b0;
        if (rv.iv && rv.ia != 0) bsy[rv.ia] = 1'b1;
      end
    end

    // 16-bit, 8-entry build with a writable register 0
    apply_p(1, 0, 0, 0,       0, 0, 7, 5, 16'd28000, 16'd20000, 0, 0, "p_preload");
    apply_p(1, 0, 0, 0,       0, 0, 0, 1, 16'd0,     16'd4000,  0, 0, "p_reg0");
    apply_p(1, 1, 0, 16'hFFFF, 0, 0, 0, 0, 16'hFFFF,  16'hFFFF,  0, 0, "p_bypass0");
    apply_p(1, 0, 0, 0,       1, 0, 0, 2, 16'hFFFF,  16'd8000,  0, 0, "p_issue0");
    apply_p(1, 0, 0, 0,       0, 0, 0, 2, 16'hFFFF,  16'd8000,  1, 0, "p_busy0");
    apply_p(1, 1, 0, 16'h0001, 0, 0, 6, 0, 16'd24000, 16'h0001,  0, 1, "p_rewrite0");
    apply_p(1, 0, 0, 0,       0, 0, 0, 6, 16'h0001,  16'd24000, 0, 0, "p_cleared0");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
